// File: rtl/tm1638_key_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_key_reader_if
// Purpose  : TM1638 3-wire bus plus bus-arbitration handshake, as seen by the
//            key reader.
// Ports    : bus_req  - reader asks for the shared TM1638 bus
//            bus_gnt  - arbiter grants the bus to the reader
//            tm_stb   - TM1638 STB (active-low frame strobe)
//            tm_clk   - TM1638 CLK
//            dio_o    - DIO value driven by the reader
//            dio_oe   - 1 = reader drives DIO, 0 = chip drives DIO
//            dio_i    - DIO as seen by the reader (already synchronised)
// Modports : master - the key reader; slave - the chip/arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface tm1638_key_reader_if;
  logic bus_req;
  logic bus_gnt;
  logic tm_stb;
  logic tm_clk;
  logic dio_o;
  logic dio_oe;
  logic dio_i;

  modport master (
    output bus_req,
    output tm_stb,
    output tm_clk,
    output dio_o,
    output dio_oe,
    input  bus_gnt,
    input  dio_i
  );

  modport slave (
    input  bus_req,
    input  tm_stb,
    input  tm_clk,
    input  dio_o,
    input  dio_oe,
    output bus_gnt,
    output dio_i
  );
endinterface
`default_nettype wire

// File: rtl/tm1638_key_reader.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_key_reader
// Purpose  : Periodically reads the 8 push buttons of a TM1638 board. Each
//            poll requests the shared bus, sends read-key command 0x42,
//            shifts in 4 scan bytes and publishes an active-high key vector.
// Ports    : clk        - system clock
//            rst        - asynchronous active-high reset
//            bus        - TM1638 bus + req/gnt handshake (master modport)
//            keys       - key state, bit i = button S(i+1)
//            keys_valid - one-cycle pulse when keys is refreshed
//            busy       - high from bus request until back in idle
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_key_reader #(
  parameter int CLK_MHZ    = 27,
  parameter int TM_CLK_KHZ = 500,
  parameter int WAIT_US    = 2,
  parameter int POLL_US    = 10000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  tm1638_key_reader_if.master    bus,
  output logic [7:0]             keys,
  output logic                   keys_valid,
  output logic                   busy
);

  // Cycles per tm_clk phase, command-to-read gap, and poll period.
  localparam int c_half    = CLK_MHZ * 1000 / (2 * TM_CLK_KHZ);
  localparam int c_wait    = WAIT_US * CLK_MHZ;
  localparam int c_poll    = POLL_US * CLK_MHZ;
  localparam int c_cnt_max = (c_half > c_wait) ? c_half : c_wait;
  localparam int c_cnt_w   = (c_cnt_max < 2) ? 1 : $clog2(c_cnt_max);
  localparam int c_poll_w  = (c_poll < 2) ? 1 : $clog2(c_poll);

  localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(c_half - 1);
  localparam logic [c_cnt_w-1:0]  c_wait_last = c_cnt_w'(c_wait - 1);
  localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(c_poll - 1);
  localparam logic [7:0]          c_cmd       = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_SETUP = 3'd2,
    S_CMD   = 3'd3,
    S_WAIT  = 3'd4,
    S_READ  = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_poll_w-1:0]  r_poll;
  logic                 r_pending;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_phase;   // 0 = tm_clk low phase, 1 = high phase
  logic [4:0]           r_bit;
  logic [7:0]           r_scan;    // only the key-carrying scan bits are kept
  logic [7:0]           r_keys;
  logic                 r_keys_valid;

  logic w_take_pending;
  logic w_poll_wrap;
  logic w_half_end;
  logic w_wait_end;
  logic w_sample;
  logic w_stb;
  logic w_tclk;
  logic w_dio_o;
  logic w_dio_oe;

  assign w_poll_wrap = (r_poll == c_poll_last);
  assign w_half_end  = (r_cnt == c_half_last);
  assign w_wait_end  = (r_cnt == c_wait_last);
  // The chip's data is taken on the first cycle of each high phase,
  // i.e. exactly when tm_clk rises.
  assign w_sample    = (r_state == S_READ) && r_phase && (r_cnt == '0);

  // --------------------------------------------------------------------------
  // Poll timer: a wrap arms one pending poll; wraps are dropped while a poll
  // is already pending or a transaction is in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_poll_wrap) r_poll <= '0;
      else             r_poll <= r_poll + 1'b1;

      if (w_take_pending)                         r_pending <= 1'b0;
      else if (w_poll_wrap && r_state == S_IDLE)  r_pending <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next state and bus outputs. Outputs decode straight from the registered
  // state so an asynchronous reset returns the bus to idle levels at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_take_pending = 1'b0;
    w_stb          = 1'b1;
    w_tclk         = 1'b1;
    w_dio_o        = 1'b1;
    w_dio_oe       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_take_pending = 1'b1;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_stb    = 1'b0;
        w_dio_oe = 1'b1;
        if (w_half_end) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        w_stb    = 1'b0;
        w_dio_oe = 1'b1;
        w_tclk   = r_phase;
        // r_bit advances on entry to a low phase, so DIO only moves there.
        w_dio_o  = c_cmd[r_bit[2:0]];
        if (w_half_end && r_phase && r_bit == 5'd7) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_stb = 1'b0;
        if (w_wait_end) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_stb  = 1'b0;
        w_tclk = r_phase;
        if (w_half_end && r_phase && r_bit == 5'd31) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_half_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase / bit timing. Everything restarts from zero on a state change.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        S_SETUP, S_WAIT, S_HOLD: r_cnt <= r_cnt + 1'b1;
        S_CMD, S_READ: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            if (r_phase) r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan capture and key publish. Read bit n is bit n%8 of scan byte n/8;
  // bit 0 of byte i is button S(i+1), bit 4 of byte i is button S(i+5).
  // All 8 key bits are rewritten every poll, and keys is loaded only on the
  // READ->HOLD step, so a reset mid-read never leaves a partial update.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan       <= '0;
      r_keys       <= '0;
      r_keys_valid <= 1'b0;
    end else begin
      if (w_sample && r_bit[2:0] == 3'd0) r_scan[{1'b0, r_bit[4:3]}] <= bus.dio_i;
      if (w_sample && r_bit[2:0] == 3'd4) r_scan[{1'b1, r_bit[4:3]}] <= bus.dio_i;

      if (r_state == S_READ && w_state_nxt == S_HOLD) begin
        r_keys       <= r_scan;
        r_keys_valid <= 1'b1;
      end else begin
        r_keys_valid <= 1'b0;
      end
    end
  end

  assign bus.tm_stb  = w_stb;
  assign bus.tm_clk  = w_tclk;
  assign bus.dio_o   = w_dio_o;
  assign bus.dio_oe  = w_dio_oe;
  assign bus.bus_req = (r_state != S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign keys        = r_keys;
  assign keys_valid  = r_keys_valid;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_key_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_key_reader
// Purpose  : Self-checking bench for tm1638_key_reader. A behavioural TM1638
//            returns programmable scan bytes; expected keys come from a
//            button-to-scan-bit model, timings from the parameter arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_key_reader;

  localparam int CLK_MHZ    = 4;
  localparam int TM_CLK_KHZ = 1000;
  localparam int WAIT_US    = 2;
  localparam int POLL_US    = 1;
  localparam int HALF       = CLK_MHZ * 1000 / (2 * TM_CLK_KHZ);
  localparam int W          = WAIT_US * CLK_MHZ;
  localparam int P          = POLL_US * CLK_MHZ;
  localparam int STB_LOW    = HALF + 16 * HALF + W + 64 * HALF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys;
  logic       keys_valid;
  logic       busy;

  tm1638_key_reader_if tmif ();

  tm1638_key_reader #(
    .CLK_MHZ    (CLK_MHZ),
    .TM_CLK_KHZ (TM_CLK_KHZ),
    .WAIT_US    (WAIT_US),
    .POLL_US    (POLL_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (tmif.master),
    .keys       (keys),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // --------------------------------------------------------------------------
  // Behavioural TM1638: after the 8 command clocks it puts one scan bit on
  // DIO at every falling tm_clk edge, byte 0 first, LSB first.
  // --------------------------------------------------------------------------
  logic [7:0] chip_bytes [4];
  int         chip_edges   = 0;
  logic       chip_reading = 1'b0;

  always @(negedge tmif.tm_clk or posedge tmif.tm_stb) begin
    if (tmif.tm_stb) begin
      chip_edges   = 0;
      chip_reading = 1'b0;
      tmif.dio_i   = 1'b1;
    end else begin
      if (chip_edges >= 8 && chip_edges < 40) begin
        chip_reading = 1'b1;
        tmif.dio_i   = chip_bytes[(chip_edges - 8) / 8][(chip_edges - 8) % 8];
      end
      chip_edges++;
    end
  end

  // Button S(s+1) lives in scan byte s%4, bit 0 for s<4 and bit 4 otherwise.
  function automatic logic [7:0] model_keys(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] stream;
    logic [7:0]  k;
    stream = {b3, b2, b1, b0};
    k = '0;
    for (int s = 0; s < 8; s++) k[s] = stream[(s % 4) * 8 + (s / 4) * 4];
    return k;
  endfunction

  // Results of the last run_txn.
  logic [7:0] got_cmd;
  int         got_cmd_n, got_stb_low, got_valid, oe_bad, clk_bad, pre_bad, start_lat;
  logic [7:0] got_keys;
  bit         timed_out;

  // One full transaction, observed on the falling system-clock edge.
  task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input int gnt_delay);
    int   req_cyc, gnt_cyc;
    bit   req_seen, granted, done;
    logic prev_clk, prev_stb;
    chip_bytes[0] = b0; chip_bytes[1] = b1; chip_bytes[2] = b2; chip_bytes[3] = b3;
    got_cmd = '0; got_cmd_n = 0; got_stb_low = 0; got_valid = 0; got_keys = '0;
    oe_bad = 0; clk_bad = 0; pre_bad = 0; start_lat = -1;
    req_seen = 0; granted = 0; done = 0; req_cyc = 0; gnt_cyc = 0;
    prev_clk = tmif.tm_clk; prev_stb = tmif.tm_stb;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (!tmif.tm_stb) got_stb_low++;
      if (!tmif.tm_stb && prev_stb && granted && start_lat < 0) start_lat = cyc - gnt_cyc;
      if (tmif.dio_oe && (tmif.tm_stb || chip_reading)) oe_bad++;
      if (tmif.tm_stb && prev_stb && tmif.tm_clk !== prev_clk) clk_bad++;
      if (!tmif.tm_stb && tmif.tm_clk && !prev_clk && tmif.dio_oe) begin
        got_cmd = {tmif.dio_o, got_cmd[7:1]};
        got_cmd_n++;
      end
      if (req_seen && !granted && (!tmif.tm_stb || !tmif.tm_clk)) pre_bad++;
      if (keys_valid) begin
        got_valid++;
        got_keys = keys;
      end
      if (got_valid > 0 && !tmif.bus_req) done = 1;
      prev_clk = tmif.tm_clk;
      prev_stb = tmif.tm_stb;
      if (tmif.bus_req && !req_seen) begin
        req_seen = 1;
        req_cyc  = cyc;
      end
      if (req_seen && !granted && cyc - req_cyc >= gnt_delay) begin
        granted      = 1;
        gnt_cyc      = cyc;
        tmif.bus_gnt = 1'b1;
      end
      if (keys_valid) tmif.bus_gnt = 1'b0;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tmif.bus_gnt = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (tmif.tm_stb !== 1'b1) begin n_err++; $display("FAIL reset_stb: got %b expected 1", tmif.tm_stb); end
    n_vec++; if (tmif.tm_clk !== 1'b1) begin n_err++; $display("FAIL reset_tmclk: got %b expected 1", tmif.tm_clk); end
    n_vec++; if (tmif.dio_o !== 1'b1) begin n_err++; $display("FAIL reset_dio_o: got %b expected 1", tmif.dio_o); end
    n_vec++; if (tmif.dio_oe !== 1'b0) begin n_err++; $display("FAIL reset_dio_oe: got %b expected 0", tmif.dio_oe); end
    n_vec++; if (tmif.bus_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", tmif.bus_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (keys !== 8'h00) begin n_err++; $display("FAIL reset_keys: got %h expected 00", keys); end
    n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", keys_valid); end
    rst = 1'b0;
    begin
      int c;
      for (c = 0; c < P + 4 && !tmif.bus_req; c++) @(negedge clk);
      n_vec++;
      if (tmif.bus_req !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL first_poll_req: got req=%b busy=%b after %0d cycles expected 1/1", tmif.bus_req, busy, c);
      end
    end
  endtask

  task automatic test_normal_read();
    run_txn(8'h01, 8'h10, 8'h00, 8'h11, 0);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL normal_timeout: got timeout expected completion"); end
    n_vec++; if (got_cmd_n != 8 || got_cmd !== 8'h42) begin n_err++; $display("FAIL normal_cmd: got %h (%0d bits) expected 42 (8 bits)", got_cmd, got_cmd_n); end
    n_vec++; if (got_keys !== 8'hA9) begin n_err++; $display("FAIL normal_keys: got %h expected a9", got_keys); end
    n_vec++; if (got_valid != 1) begin n_err++; $display("FAIL normal_valid_cycles: got %0d expected 1", got_valid); end
    n_vec++; if (got_stb_low != STB_LOW) begin n_err++; $display("FAIL normal_stb_low: got %0d expected %0d", got_stb_low, STB_LOW); end
    n_vec++; if (oe_bad != 0) begin n_err++; $display("FAIL normal_dio_oe: got %0d bad cycles expected 0", oe_bad); end
    n_vec++; if (clk_bad != 0) begin n_err++; $display("FAIL normal_clk_stb_high: got %0d edges expected 0", clk_bad); end
    n_vec++; if (start_lat != 1) begin n_err++; $display("FAIL normal_start_latency: got %0d expected 1", start_lat); end
  endtask

  task automatic test_grant_delay();
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    run_txn(b[0], b[1], b[2], b[3], 50);
    n_vec++; if (pre_bad != 0) begin n_err++; $display("FAIL grant_wait_idle_bus: got %0d active cycles expected 0", pre_bad); end
    n_vec++; if (start_lat != 1) begin n_err++; $display("FAIL grant_start_latency: got %0d expected 1", start_lat); end
    n_vec++; if (got_keys !== model_keys(b[0], b[1], b[2], b[3]) || timed_out) begin
      n_err++; $display("FAIL grant_keys: got %h expected %h", got_keys, model_keys(b[0], b[1], b[2], b[3]));
    end
  endtask

  task automatic test_random_reads();
    logic [7:0] b [4];
    logic [7:0] exp;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      exp = model_keys(b[0], b[1], b[2], b[3]);
      run_txn(b[0], b[1], b[2], b[3], int'($urandom_range(0, 10)));
      n_vec++; if (got_keys !== exp || timed_out) begin n_err++; $display("FAIL random_keys[%0d]: got %h expected %h", t, got_keys, exp); end
      n_vec++; if (got_valid != 1) begin n_err++; $display("FAIL random_valid[%0d]: got %0d expected 1", t, got_valid); end
      n_vec++; if (got_stb_low != STB_LOW || oe_bad != 0) begin
        n_err++; $display("FAIL random_frame[%0d]: got stb_low=%0d oe_bad=%0d expected %0d/0", t, got_stb_low, oe_bad, STB_LOW);
      end
    end
  endtask

  task automatic test_all_keys();
    run_txn(8'h11, 8'h11, 8'h11, 8'h11, 2);
    n_vec++; if (got_keys !== 8'hFF) begin n_err++; $display("FAIL all_pressed_keys: got %h expected ff", got_keys); end
    n_vec++; if (got_valid != 1) begin n_err++; $display("FAIL all_pressed_valid: got %0d expected 1", got_valid); end
    run_txn(8'h00, 8'h00, 8'h00, 8'h00, 2);
    n_vec++; if (got_keys !== 8'h00 || keys !== 8'h00) begin n_err++; $display("FAIL all_released_keys: got %h/%h expected 00", got_keys, keys); end
    n_vec++; if (got_valid != 1) begin n_err++; $display("FAIL all_released_valid: got %0d expected 1", got_valid); end
  endtask

  task automatic test_reset_mid_read();
    int c;
    int vseen;
    chip_bytes[0] = 8'hFF; chip_bytes[1] = 8'hFF; chip_bytes[2] = 8'hFF; chip_bytes[3] = 8'hFF;
    for (c = 0; c < 200 && !tmif.bus_req; c++) @(negedge clk);
    tmif.bus_gnt = 1'b1;
    // Falling edge number 18 starts read bit 10.
    for (c = 0; c < 400 && chip_edges < 19; c++) @(negedge clk);
    n_vec++; if (chip_edges < 19) begin n_err++; $display("FAIL midread_reach_bit10: got %0d edges expected 19", chip_edges); end
    rst = 1'b1;
    tmif.bus_gnt = 1'b0;
    #1;
    n_vec++; if (tmif.tm_stb !== 1'b1 || tmif.dio_oe !== 1'b0 || tmif.bus_req !== 1'b0) begin
      n_err++; $display("FAIL midread_bus_idle: got stb=%b oe=%b req=%b expected 1/0/0", tmif.tm_stb, tmif.dio_oe, tmif.bus_req);
    end
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    for (c = 0; c < 30; c++) begin
      @(negedge clk);
      if (keys_valid) vseen++;
    end
    n_vec++; if (vseen != 0) begin n_err++; $display("FAIL midread_no_valid: got %0d pulses expected 0", vseen); end
    n_vec++; if (keys !== 8'h00) begin n_err++; $display("FAIL midread_keys: got %h expected 00", keys); end
  endtask

  task automatic test_back_to_back();
    int   lows[$];
    int   gaps[$];
    int   lo, hi, vcnt, kbad, badlen, badgap;
    bit   seen_fall;
    logic prev_stb;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) chip_bytes[i] = 8'($urandom);
    exp = model_keys(chip_bytes[0], chip_bytes[1], chip_bytes[2], chip_bytes[3]);
    lo = 0; hi = 0; vcnt = 0; kbad = 0; seen_fall = 0;
    prev_stb = tmif.tm_stb;
    tmif.bus_gnt = 1'b1;
    for (int c = 0; c < 2000 && lows.size() < 4; c++) begin
      @(negedge clk);
      if (keys_valid) begin
        vcnt++;
        if (keys !== exp) kbad++;
      end
      if (!tmif.tm_stb && prev_stb) begin
        if (lows.size() > 0) gaps.push_back(hi);
        seen_fall = 1;
        lo = 0;
      end
      if (tmif.tm_stb && !prev_stb && seen_fall) begin
        lows.push_back(lo);
        hi = 0;
      end
      if (!tmif.tm_stb) lo++;
      else              hi++;
      prev_stb = tmif.tm_stb;
    end
    tmif.bus_gnt = 1'b0;
    badlen = 0;
    foreach (lows[i]) if (lows[i] != STB_LOW) badlen++;
    badgap = 0;
    foreach (gaps[i]) if (gaps[i] < HALF + 1 || gaps[i] > HALF + P + 2) badgap++;
    n_vec++; if (lows.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d frames expected 4", lows.size()); end
    n_vec++; if (badlen != 0) begin n_err++; $display("FAIL b2b_stb_low: got %0d bad frames expected 0", badlen); end
    n_vec++; if (gaps.size() != 3 || badgap != 0) begin
      n_err++; $display("FAIL b2b_gap: got %0d gaps (%0d out of %0d..%0d) expected 3 in range", gaps.size(), badgap, HALF + 1, HALF + P + 2);
    end
    n_vec++; if (vcnt != lows.size() || kbad != 0) begin
      n_err++; $display("FAIL b2b_keys: got %0d pulses %0d wrong expected %0d pulses 0 wrong (keys %h)", vcnt, kbad, lows.size(), exp);
    end
    repeat (HALF * 90 + W + 20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal_read();
    test_grant_delay();
    test_random_reads();
    test_all_keys();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm1638_key_reader.md
Name: tm1638_key_reader

Overview:
Reads the 8-button key matrix of a TM1638 board over the chip's 3-wire serial bus (STB/CLK/DIO). It is the input-side counterpart of the display writer, which drives LEDs and 7-segment data to the same chip. The block polls the chip periodically by issuing read-key command 0x42, shifting in 4 scan bytes and decoding them into an active-high key vector. That vector feeds the `key` input of the application driver. The bus is shared with the display writer through a req/gnt handshake.

Parameters:
- clk_mhz, 27: system clock frequency in MHz.
- tm_clk_khz, 500: TM1638 serial clock frequency. HALF = clk_mhz*1000/(2*tm_clk_khz) system cycles per tm_clk phase; HALF must be at least 1.
- wait_us, 2: gap between the command byte and the first read bit. W = wait_us*clk_mhz cycles.
- poll_us, 10000: poll interval. P = poll_us*clk_mhz cycles.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- bus_gnt, in, 1: TM1638 bus granted to this block.
- bus_req, out, 1: bus request.
- tm_stb, out, 1: TM1638 STB (strobe).
- tm_clk, out, 1: TM1638 CLK.
- dio_o, out, 1: DIO output value.
- dio_oe, out, 1: DIO output enable. 1 = drive; 0 = tri-state, chip drives.
- dio_i, in, 1: DIO input. Already synchronised by a 2-flop synchroniser at the top level.
- keys, out, 8: debounced-by-polling key state, active-high, bit i = button S(i+1).
- keys_valid, out, 1: one-cycle pulse when `keys` is updated.
- busy, out, 1: high from REQ until IDLE.

Behaviour:
- Reset values:
  - tm_stb=1, tm_clk=1, dio_o=1, dio_oe=0.
  - bus_req=0, busy=0, keys=8'h00, keys_valid=0.
  - Poll counter = 0, pending = 0, state = IDLE.
- Poll counter:
  - Counts 0..P-1 continuously and wraps.
  - On wrap it sets `pending`.
  - Further wraps while pending or busy are dropped; no queueing beyond 1.
- FSM states: IDLE, REQ, SETUP, CMD, WAIT, READ, HOLD.
  - IDLE: if pending, clear pending and go to REQ; bus_req=1.
  - REQ: wait for bus_gnt=1, with no timeout. bus_gnt is sampled only here; a later deassertion is ignored until HOLD ends.
  - SETUP (HALF cycles): tm_stb=0, tm_clk=1, dio_oe=1.
  - CMD: 8 bits, LSB first, of 8'h42 (bit sequence 0,1,0,0,0,0,1,0).
    - Each bit is HALF cycles with tm_clk=0, then HALF cycles with tm_clk=1.
    - dio_o changes only on the first cycle of the low phase.
  - WAIT (W cycles): tm_clk=1, dio_oe=0, dio_o=1.
  - READ: 32 bits, each a low phase then a high phase of HALF cycles.
    - dio_i is sampled on the cycle tm_clk goes 0->1.
    - Bits shift LSB first into byte0..byte3.
  - HOLD (HALF cycles): tm_stb=1, tm_clk=1, dio_oe=0.
    - keys and keys_valid update on the first HOLD cycle.
    - At HOLD end: bus_req=0, busy=0, return to IDLE.
- Timing: tm_stb is low for exactly HALF + 16*HALF + W + 64*HALF cycles.
- Decode: keys[i] = byte_i[0] and keys[i+4] = byte_i[4], for i = 0..3. All other scan bits are ignored.
- The keys register holds its value between polls and is never partially updated.
- dio_oe is never 1 while tm_stb=1. No cycle has dio_oe=1 during WAIT or READ.
- Reset mid-transaction: all outputs return immediately to their reset values; no keys update occurs.
- bus_gnt high while idle has no effect.
- bus_req is held continuously from REQ to the end of HOLD.

Test Plan:
- Normal read (clk_mhz=4, tm_clk_khz=1000 => HALF=2; W=8; TM1638 BFM returns bytes 01,10,00,11) -> CMD bits on DIO are 0,1,0,0,0,0,1,0. keys=8'hA9, keys_valid is high for 1 cycle, tm_stb is low for exactly 170 cycles.
- Grant delay: hold bus_gnt=0 for 50 cycles after bus_req rises -> tm_stb stays 1 and tm_clk stays 1 throughout. The transaction starts on the cycle after bus_gnt=1 is sampled.
- Bus direction: monitor the whole transaction -> dio_oe=1 only in SETUP/CMD, dio_oe=0 during all 32 read bits. No tm_clk edges occur while tm_stb=1.
- Poll overrun (poll_us=1, P=4 < transaction length) -> back-to-back transactions. Each is separated by a HOLD of 2 cycles plus an IDLE/REQ of at least 1 cycle; at most 1 pending poll is kept.
- Reset mid-READ, asserted at bit 10 -> next cycle tm_stb=1, dio_oe=0, bus_req=0; keys stays 8'h00; no keys_valid pulse.
- All keys pressed (bytes 11,11,11,11), then all released (bytes 00 ×4) -> keys=8'hFF then 8'h00, each with exactly one keys_valid pulse.
